// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - per-output round-robin scheduler and crossbar for the 4-port switch
// Burst ownership (up to MAX_BURST grant cycles) is enabled by defining SWITCH_ARB_BURST_EN.
module switch_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]           xfer_i,
    input  logic [NUM_PORTS*WIDTH-1:0]     data_i,
    output logic [NUM_PORTS-1:0]           grant_o,
    output logic [NUM_PORTS-1:0]           valid_o,
    output logic [NUM_PORTS*WIDTH-1:0]     data_o,
    output logic                           misroute_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef SWITCH_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int                   BURST_LEN = BURST_EN ? MAX_BURST : 1;
    localparam logic [4:0]           BCNT_LAST = 5'(BURST_LEN - 1);
    localparam logic [NUM_PORTS-1:0] ONE       = 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    logic [NUM_PORTS-1:0] dest_a [NUM_PORTS];
    logic [WIDTH-1:0]     data_a [NUM_PORTS];
    logic [NUM_PORTS-1:0] gmat   [NUM_PORTS];
    logic [NUM_PORTS-1:0] drop_vec;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign dest_a[i]  = dest_i[i*NUM_PORTS +: NUM_PORTS];
        assign data_a[i]  = data_i[i*WIDTH +: WIDTH];
        assign grant_o[i] = |gmat[i];
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        state_e           state_q, state_d;
        logic [PW-1:0]    owner_q, owner_d;
        logic [PW-1:0]    rr_q, rr_d;
        logic [4:0]       bcnt_q, bcnt_d;
        logic             gq_q;
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic             drop_q, drop_d;
        logic [PW:0]      scan;

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            rr_d    = rr_q;
            bcnt_d  = bcnt_q;
            scan    = '0;
            if (state_q == IDLE) begin
                // Scan downward so the eligible input closest to rr_q is assigned last and wins
                for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                    scan = {1'b0, rr_q} + (PW+1)'(k);
                    if (scan >= (PW+1)'(NUM_PORTS)) begin
                        scan = scan - (PW+1)'(NUM_PORTS);
                    end
                    if (req_i[scan[PW-1:0]] && dest_a[scan[PW-1:0]] == (ONE << j)) begin
                        state_d = GRANT;
                        owner_d = scan[PW-1:0];
                        bcnt_d  = '0;
                    end
                end
            end else begin
                bcnt_d = bcnt_q + 5'd1;
                if (!req_i[owner_q] || !dest_a[owner_q][j] || bcnt_q == BCNT_LAST) begin
                    state_d = IDLE;
                    rr_d    = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + PW'(1);
                end
            end
        end

        // owner_q still names the source in the read cycle that follows a grant cycle
        always_comb begin
            valid_d = 1'b0;
            data_d  = data_q;
            drop_d  = 1'b0;
            if (gq_q && xfer_i[owner_q]) begin
                if (dest_a[owner_q][j]) begin
                    valid_d = 1'b1;
                    data_d  = data_a[owner_q];
                end else begin
                    drop_d = BURST_EN;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                owner_q <= '0;
                rr_q    <= '0;
                bcnt_q  <= '0;
                gq_q    <= 1'b0;
                valid_q <= 1'b0;
                data_q  <= '0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                rr_q    <= rr_d;
                bcnt_q  <= bcnt_d;
                gq_q    <= (state_q == GRANT);
                valid_q <= valid_d;
                data_q  <= data_d;
                drop_q  <= drop_d;
            end
        end

        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_gnt
            assign gmat[i][j] = (state_q == GRANT) && (owner_q == PW'(i));
        end

        assign valid_o[j]                 = valid_q;
        assign data_o[j*WIDTH +: WIDTH]   = data_q;
        assign drop_vec[j]                = drop_q;
    end

    assign misroute_o = |drop_vec;

endmodule

// File: tb/tb_switch_arbiter.sv
// tb/tb_switch_arbiter.sv - vector table, burst sequences and random run against a reference model
module tb_switch_arbiter;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef SWITCH_ARB_BURST_EN
    localparam int BEN = 1;
`else
    localparam int BEN = 0;
`endif
    localparam int BLEN = (BEN != 0) ? MB : 1;

    logic        clk;
    logic        rst;
    logic [3:0]  req, xfer, grant, valid;
    logic [15:0] dest;
    logic [31:0] din, dout;
    logic        mis;

    switch_arbiter #(.WIDTH(W), .NUM_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_i(req), .dest_i(dest), .xfer_i(xfer), .data_i(din),
        .grant_o(grant), .valid_o(valid), .data_o(dout), .misroute_o(mis)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Reference model: per output, busy = grant cycles used so far (-1 when idle)
    int         m_busy [NP];
    int         m_owner[NP];
    int         m_ptr  [NP];
    bit         m_gq   [NP];
    logic [7:0] m_data [NP];
    logic [3:0] m_valid;
    logic       m_mis;

    function automatic logic [3:0] model_grant();
        logic [3:0] g = '0;
        for (int j = 0; j < NP; j++) if (m_busy[j] >= 0) g[m_owner[j]] = 1'b1;
        return g;
    endfunction

    function automatic logic [31:0] model_data();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic model_step();
        logic [3:0] nv;
        logic       nm;
        int         o, i;
        if (rst) begin
            for (int j = 0; j < NP; j++) begin
                m_busy[j] = -1; m_owner[j] = 0; m_ptr[j] = 0; m_gq[j] = 0; m_data[j] = '0;
            end
            m_valid = '0;
            m_mis   = 1'b0;
            return;
        end
        nv = '0;
        nm = 1'b0;
        for (int j = 0; j < NP; j++) begin
            o = m_owner[j];
            if (m_gq[j] && xfer[o]) begin
                if (dest[o*4 + j]) begin
                    nv[j]     = 1'b1;
                    m_data[j] = din[o*8 +: 8];
                end else if (BEN != 0) begin
                    nm = 1'b1;
                end
            end
        end
        for (int j = 0; j < NP; j++) begin
            m_gq[j] = (m_busy[j] >= 0);
            if (m_busy[j] < 0) begin
                for (int k = 0; k < NP; k++) begin
                    i = (m_ptr[j] + k) % NP;
                    if (req[i] && dest[i*4 +: 4] == (4'b0001 << j)) begin
                        m_owner[j] = i;
                        m_busy[j]  = 0;
                        break;
                    end
                end
            end else begin
                o = m_owner[j];
                if (!req[o] || !dest[o*4 + j] || m_busy[j] + 1 >= BLEN) begin
                    m_busy[j] = -1;
                    m_ptr[j]  = (o + 1) % NP;
                end else begin
                    m_busy[j]++;
                end
            end
        end
        m_valid = nv;
        m_mis   = nm;
    endtask

    task automatic cycle(input string tag, input int idx);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".grant"}, idx, 32'(grant), 32'(model_grant()));
        chk({tag, ".valid"}, idx, 32'(valid), 32'(m_valid));
        chk({tag, ".data"},  idx, dout, model_data());
        chk({tag, ".mis"},   idx, 32'(mis), 32'(m_mis));
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] dest;
        logic [3:0]  xfer;
        logic [31:0] data;
        logic [3:0]  eg;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic        em;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] ds, input logic [3:0] xf,
                       input logic [31:0] dt, input logic [3:0] eg, input logic [3:0] ev,
                       input logic [31:0] ed, input logic em);
        vec_t v;
        v.rst = r; v.req = rq; v.dest = ds; v.xfer = xf; v.data = dt;
        v.eg = eg; v.ev = ev; v.ed = ed; v.em = em;
        tv.push_back(v);
    endtask

`ifdef SWITCH_ARB_BURST_EN
    task automatic burst_seq(input int bad, input string tag);
        int         rem = 6;
        int         rd  = 0;
        int         nmis = 0;
        logic [3:0] pg = '0;
        logic [3:0] eg;
        logic [15:0] obs = '0;
        logic [7:0] got[$];
        bit         bad_out = 0;
        rst = 1'b1; req = '0; dest = '0; xfer = '0; din = '0;
        cycle(tag, -1);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            eg = model_grant();
            if (eg[1]) rem--;
            req       = '0;
            req[1]    = (rem > 0);
            xfer      = '0;
            xfer[1]   = pg[1];
            dest      = '0;
            din       = '0;
            if (rd < 6) begin
                dest[7:4] = (rd == bad) ? 4'b0100 : 4'b0001;
                din[15:8] = 8'hC0 + 8'(rd);
            end
            cycle(tag, c);
            if (xfer[1]) rd++;
            obs[c] = grant[1];
            if (valid[0]) got.push_back(dout[7:0]);
            if (mis) nmis++;
            pg = eg;
        end
        if (bad < 0) begin
            chk({tag, ".grant_pattern"}, 0, 32'(obs), 32'h0000_006F);
            chk({tag, ".valid_count"}, 0, got.size(), 6);
            for (int k = 0; k < got.size() && k < 6; k++)
                chk({tag, ".order"}, k, 32'(got[k]), 32'(8'hC0 + 8'(k)));
        end else begin
            foreach (got[k]) if (got[k] == 8'hC2) bad_out = 1;
            chk({tag, ".mis_seen"}, 0, 32'(nmis > 0), 32'd1);
            chk({tag, ".bad_dropped"}, 0, 32'(bad_out), 32'd0);
        end
    endtask
`endif

    initial begin
        logic [3:0] pg, eg;
        int         pos, own;
        rst = 1'b1; req = '0; dest = '0; xfer = '0; din = '0;

        // single request, then parallel outputs
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0001, 16'h0002, 4'b0000, 32'h0,        4'b0001, 4'b0000, 32'h0,        0);
        add(0, 4'b0000, 16'h0002, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0000, 16'h0002, 4'b0001, 32'h000000A5, 4'b0000, 4'b0010, 32'h0000A500, 0);
        add(0, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0000A500, 0);
        add(0, 4'b0011, 16'h0084, 4'b0000, 32'h0,        4'b0011, 4'b0000, 32'h0000A500, 0);
        add(0, 4'b0000, 16'h0084, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0000A500, 0);
        add(0, 4'b0000, 16'h0084, 4'b0011, 32'h00002211, 4'b0000, 4'b1100, 32'h2211A500, 0);
        // two-way contention on output 0, then rr_ptr 3 favours input 3 over input 0
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0101, 16'h0101, 4'b0000, 32'h0,        4'b0001, 4'b0000, 32'h0,        0);
        add(0, 4'b0100, 16'h0101, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0100, 16'h0101, 4'b0001, 32'h00000010, 4'b0100, 4'b0001, 32'h00000010, 0);
        add(0, 4'b0000, 16'h0101, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h00000010, 0);
        add(0, 4'b0000, 16'h0101, 4'b0100, 32'h00300000, 4'b0000, 4'b0001, 32'h00000030, 0);
        add(0, 4'b1001, 16'h1001, 4'b0000, 32'h0,        4'b1000, 4'b0000, 32'h00000030, 0);
        // zero and multi-hot destinations are never eligible
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0011, 16'h0030, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0011, 16'h0030, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        // reset during GRANT; rr_ptr restarts at 0
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0010, 16'h0010, 4'b0000, 32'h0,        4'b0010, 4'b0000, 32'h0,        0);
        add(1, 4'b0000, 16'h0010, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0000, 16'h0000, 4'b0010, 32'h0000FF00, 4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b1001, 16'h1001, 4'b0000, 32'h0,        4'b0001, 4'b0000, 32'h0,        0);
        // destination changes between grant and read: word dropped
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0001, 16'h0002, 4'b0000, 32'h0,        4'b0001, 4'b0000, 32'h0,        0);
        add(0, 4'b0000, 16'h0002, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        add(0, 4'b0000, 16'h0004, 4'b0001, 32'h00000077, 4'b0000, 4'b0000, 32'h0,        1'(BEN));
        add(0, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        // four-way fairness on output 3
        add(1, 4'b0000, 16'h0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 32'h0,        0);
        for (int k = 0; k < 5 * (BLEN + 1); k++) begin
            pos = k % (BLEN + 1);
            own = (k / (BLEN + 1)) % NP;
            add(0, 4'b1111, 16'h8888, 4'b0000, 32'h0,
                (pos < BLEN) ? (4'b0001 << own) : 4'b0000, 4'b0000, 32'h0, 0);
        end

        for (int r = 0; r < tv.size(); r++) begin
            rst = tv[r].rst; req = tv[r].req; dest = tv[r].dest; xfer = tv[r].xfer; din = tv[r].data;
            @(posedge clk);
            #1;
            chk("tbl.grant", r, 32'(grant), 32'(tv[r].eg));
            chk("tbl.valid", r, 32'(valid), 32'(tv[r].ev));
            chk("tbl.data",  r, dout, tv[r].ed);
            chk("tbl.mis",   r, 32'(mis), 32'(tv[r].em));
        end

`ifdef SWITCH_ARB_BURST_EN
        burst_seq(-1, "burst6");
        burst_seq(2, "burst_bad3");
`endif

        rst = 1'b1; req = '0; dest = '0; xfer = '0; din = '0;
        cycle("rand", -1);
        pg = '0;
        for (int n = 0; n < 1500; n++) begin
            eg  = model_grant();
            rst = ($urandom_range(0, 127) == 0);
            req = 4'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 9) < 4) begin
                    case ($urandom_range(0, 7))
                        6:       dest[i*4 +: 4] = 4'b0000;
                        7:       dest[i*4 +: 4] = 4'($urandom);
                        default: dest[i*4 +: 4] = 4'b0001 << $urandom_range(0, 3);
                    endcase
                end
                xfer[i] = pg[i] && ($urandom_range(0, 9) != 0);
            end
            din = $urandom;
            cycle("rand", n);
            pg = eg;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
